pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 The block SHALL have parameter MEM_WAIT_CYCLES, default 4, the number of cycles the pipeline is frozen per data-memory access (legal range 2..15).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- id_src1  in  4  Rn address of instruction in ID
- id_src2  in  4  second source address of instruction in ID
- id_uses_src1  in  1  ID instruction reads src1
- id_two_src  in  1  ID instruction reads src2
- exe_dest  in  4  destination of instruction in EXE (ID/EX reg output)
- exe_wb_en  in  1  EXE instruction writes back
- mem_dest  in  4  destination of instruction in MEM (EXE/MEM reg output)
- mem_wb_en  in  1  MEM instruction writes back
- branch_taken  in  1  branch resolved taken (ID/EX reg output)
- mem_r_en  in  1  MEM-stage load request
- mem_w_en  in  1  MEM-stage store request
- freeze_front  out  1  hold PC and IF/ID register
- freeze_pipe  out  1  hold all stage registers (memory wait)
- flush_if_id  out  1  squash IF/ID register
- flush_id_ex  out  1  squash ID/EX register (bubble)
- mem_busy  out  1  memory FSM not IDLE
- mem_done  out  1  one-cycle pulse, access complete
- stall_cnt  out  16  saturating count of stall cycles

Function
REQ-004 hazard SHALL be (id_uses_src1 & ((exe_wb_en & id_src1==exe_dest) | (mem_wb_en & id_src1==mem_dest))) | (id_two_src & same terms with id_src2).
REQ-005 The memory FSM SHALL have states IDLE, WAIT, DONE with a 4-bit down-counter.
REQ-006 In IDLE with mem_r_en|mem_w_en: freeze_pipe=1 same cycle, counter loads MEM_WAIT_CYCLES-1, next state WAIT.
REQ-007 In WAIT: freeze_pipe=1; counter==1 -> DONE, else counter decrements.
REQ-008 In DONE: freeze_pipe=0, mem_done=1 for exactly that cycle, next state IDLE unconditionally.
REQ-009 Each access SHALL therefore freeze exactly MEM_WAIT_CYCLES consecutive cycles followed by one unfrozen DONE cycle; a request visible in the cycle after DONE SHALL start a new access.
REQ-010 mem_busy SHALL be 1 in WAIT and DONE, 0 in IDLE.
REQ-011 Request inputs SHALL be ignored in WAIT and DONE.
REQ-012 When freeze_pipe=0 and branch_taken=1: flush_if_id=1, flush_id_ex=1, freeze_front=0 (branch overrides hazard).
REQ-013 When freeze_pipe=0, branch_taken=0, hazard=1: freeze_front=1, flush_id_ex=1, flush_if_id=0.
REQ-014 When freeze_pipe=1: flush_if_id=0, flush_id_ex=0, freeze_front=1.
REQ-015 Control outputs SHALL be combinational from state and inputs, with no registered latency.
REQ-016 stall_cnt SHALL increment on every cycle with freeze_front=1, saturate at 0xFFFF, and never wrap.

Reset
REQ-017 While rst=1: state=IDLE, counter=0, stall_cnt=0, and all other outputs forced 0 regardless of inputs.
REQ-018 Reset asserted mid-access SHALL abort the access; after release the FSM restarts from IDLE and re-samples requests.

Structure
REQ-019 Shared package arm_ctrl_pkg SHALL hold the FSM state enum, REG_ADDR_W=4, and the MEM_WAIT_CYCLES default.
REQ-020 Hazard comparison SHALL be a combinational sub-module hazard_detector.
REQ-021 The FSM, counter and stall_cnt SHALL reside in pipeline_controller.

Verification
REQ-022 Load with MEM_WAIT_CYCLES=4: mem_r_en=1 at cycle 0 -> freeze_pipe=1 cycles 0-3, mem_done=1 cycle 4, mem_busy=1 cycles 1-4.
REQ-023 exe_wb_en=1, exe_dest=3, id_src1=3, id_uses_src1=1 -> freeze_front=1, flush_id_ex=1, flush_if_id=0, stall_cnt +1.
REQ-024 Branch plus hazard: branch_taken=1 with the REQ-023 hazard -> flush_if_id=1, flush_id_ex=1, freeze_front=0.
REQ-025 Back-to-back stores: mem_w_en held 1 -> freeze pattern repeats 4 frozen / 1 unfrozen, with mem_done every 5th cycle.
REQ-026 rst pulsed at cycle 2 of an access -> outputs 0 immediately; after release with no request, FSM stays IDLE and mem_busy=0.
REQ-027 Force 65 540 stall cycles -> stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared types and constants for the ARM pipeline control slice.
package arm_ctrl_pkg;

   localparam int unsigned REG_ADDR_W          = 4;
   localparam int unsigned MEM_WAIT_CYCLES_DEF = 4;
   localparam int unsigned MEM_CNT_W           = 4;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDone
   } mem_state_e;

endpackage

// File: rtl/hazard_detector.sv
// RAW hazard check of the ID-stage sources against the EXE and MEM destinations.
module hazard_detector
   import arm_ctrl_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] src1,
   input  logic [REG_ADDR_W-1:0] src2,
   input  logic                  uses_src1,
   input  logic                  two_src,
   input  logic [REG_ADDR_W-1:0] exe_dest,
   input  logic                  exe_wb_en,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   input  logic                  mem_wb_en,
   output logic                  hazard
);

   logic src1_hit;
   logic src2_hit;

   always_comb begin
      src1_hit = (exe_wb_en && (src1 == exe_dest)) || (mem_wb_en && (src1 == mem_dest));
      src2_hit = (exe_wb_en && (src2 == exe_dest)) || (mem_wb_en && (src2 == mem_dest));
      hazard   = (uses_src1 && src1_hit) || (two_src && src2_hit);
   end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline freeze/flush control: hazard stalls, branch flushes, data-memory wait FSM
// and a saturating stall-cycle counter.
module pipeline_controller
   import arm_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_CYCLES = MEM_WAIT_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_src1,
   input  logic [REG_ADDR_W-1:0] id_src2,
   input  logic                  id_uses_src1,
   input  logic                  id_two_src,
   input  logic [REG_ADDR_W-1:0] exe_dest,
   input  logic                  exe_wb_en,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   input  logic                  mem_wb_en,
   input  logic                  branch_taken,
   input  logic                  mem_r_en,
   input  logic                  mem_w_en,
   output logic                  freeze_front,
   output logic                  freeze_pipe,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic                  mem_busy,
   output logic                  mem_done,
   output logic [15:0]           stall_cnt
);

   localparam logic [MEM_CNT_W-1:0] CntLoad = MEM_CNT_W'(MEM_WAIT_CYCLES - 1);

   mem_state_e           state_q, state_d;
   logic [MEM_CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]          stall_cnt_q;
   logic                 hazard;
   logic                 fsm_freeze;
   logic                 fsm_busy;
   logic                 fsm_done;

   hazard_detector u_hazard (
      .src1      (id_src1),
      .src2      (id_src2),
      .uses_src1 (id_uses_src1),
      .two_src   (id_two_src),
      .exe_dest  (exe_dest),
      .exe_wb_en (exe_wb_en),
      .mem_dest  (mem_dest),
      .mem_wb_en (mem_wb_en),
      .hazard    (hazard)
   );

   // The IDLE cycle that accepts a request is itself the first frozen cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fsm_freeze = 1'b0;
      fsm_busy   = 1'b0;
      fsm_done   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mem_r_en || mem_w_en) begin
               fsm_freeze = 1'b1;
               cnt_d      = CntLoad;
               state_d    = StWait;
            end
         end
         StWait: begin
            fsm_freeze = 1'b1;
            fsm_busy   = 1'b1;
            if (cnt_q == MEM_CNT_W'(1)) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - MEM_CNT_W'(1);
            end
         end
         StDone: begin
            fsm_busy = 1'b1;
            fsm_done = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Memory freeze dominates; a taken branch squashes the hazarding instruction anyway.
   always_comb begin
      freeze_pipe  = 1'b0;
      freeze_front = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      mem_busy     = 1'b0;
      mem_done     = 1'b0;
      if (!rst) begin
         freeze_pipe = fsm_freeze;
         mem_busy    = fsm_busy;
         mem_done    = fsm_done;
         if (fsm_freeze) begin
            freeze_front = 1'b1;
         end else if (branch_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
         end else if (hazard) begin
            freeze_front = 1'b1;
            flush_id_ex  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (freeze_front && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: vector table, directed corner sequences and
// randomized traffic checked against a cycle-position reference model.
module tb_pipeline_controller;

   localparam int MWC = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
   logic       id_uses_src1, id_two_src, exe_wb_en, mem_wb_en;
   logic       branch_taken, mem_r_en, mem_w_en;
   logic       freeze_front, freeze_pipe, flush_if_id, flush_id_ex, mem_busy, mem_done;
   logic [15:0] stall_cnt;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: -1 = idle, otherwise position 0..MWC within the current access.
   int m_pos = -1;
   int m_cnt = 0;

   typedef struct {
      logic [3:0] src1;
      logic [3:0] src2;
      logic       u1;
      logic       two;
      logic [3:0] ed;
      logic       ew;
      logic [3:0] md;
      logic       mw;
      logic       br;
      logic       ff;
      logic       fi;
      logic       fe;
   } vec_t;

   vec_t tbl [10];

   pipeline_controller #(
      .MEM_WAIT_CYCLES(MWC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_uses_src1 (id_uses_src1),
      .id_two_src   (id_two_src),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .branch_taken (branch_taken),
      .mem_r_en     (mem_r_en),
      .mem_w_en     (mem_w_en),
      .freeze_front (freeze_front),
      .freeze_pipe  (freeze_pipe),
      .flush_if_id  (flush_if_id),
      .flush_id_ex  (flush_id_ex),
      .mem_busy     (mem_busy),
      .mem_done     (mem_done),
      .stall_cnt    (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk6(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_hazard();
      logic [3:0] src [2];
      logic       used [2];
      logic       h;
      h       = 1'b0;
      src[0]  = id_src1;
      src[1]  = id_src2;
      used[0] = id_uses_src1;
      used[1] = id_two_src;
      for (int s = 0; s < 2; s++) begin
         if (used[s]) begin
            if (exe_wb_en && (src[s] == exe_dest)) h = 1'b1;
            if (mem_wb_en && (src[s] == mem_dest)) h = 1'b1;
         end
      end
      return h;
   endfunction

   task automatic clear_inputs();
      id_src1      = '0;
      id_src2      = '0;
      id_uses_src1 = 1'b0;
      id_two_src   = 1'b0;
      exe_dest     = '0;
      exe_wb_en    = 1'b0;
      mem_dest     = '0;
      mem_wb_en    = 1'b0;
      branch_taken = 1'b0;
      mem_r_en     = 1'b0;
      mem_w_en     = 1'b0;
   endtask

   // One clock cycle with the currently driven inputs; observed values returned for
   // directed checks, every output also checked against the model.
   task automatic step(output logic [5:0] obs, output logic [15:0] obs_cnt);
      int   pe;
      logic req, h, e_fp, e_done, e_busy, e_ff, e_fi, e_fe;
      req = mem_r_en | mem_w_en;
      h   = model_hazard();
      if (rst) begin
         m_pos = -1;
         m_cnt = 0;
      end
      pe     = (m_pos < 0 && req) ? 0 : m_pos;
      e_fp   = !rst && (pe >= 0) && (pe < MWC);
      e_done = !rst && (pe == MWC);
      e_busy = !rst && (pe >= 1);
      e_fi   = !rst && !e_fp && branch_taken;
      e_fe   = !rst && !e_fp && (branch_taken || h);
      e_ff   = !rst && (e_fp || (!branch_taken && h));
      @(negedge clk);
      obs     = {freeze_front, freeze_pipe, flush_if_id, flush_id_ex, mem_busy, mem_done};
      obs_cnt = stall_cnt;
      chk1("model freeze_front", freeze_front, e_ff);
      chk1("model freeze_pipe", freeze_pipe, e_fp);
      chk1("model flush_if_id", flush_if_id, e_fi);
      chk1("model flush_id_ex", flush_id_ex, e_fe);
      chk1("model mem_busy", mem_busy, e_busy);
      chk1("model mem_done", mem_done, e_done);
      chk16("model stall_cnt", stall_cnt, 16'(m_cnt));
      @(posedge clk);
      if (rst) begin
         m_pos = -1;
         m_cnt = 0;
      end else begin
         m_pos = (pe < 0 || pe == MWC) ? -1 : pe + 1;
         if (e_ff && m_cnt < 65535) m_cnt++;
      end
      #1;
   endtask

   initial begin
      logic [5:0]  obs;
      logic [15:0] oc;
      logic [5:0]  exp_fp, exp_done, exp_busy;
      int          exp_inc;

      tbl[0] = '{4'd3,  4'd0, 1'b1, 1'b0, 4'd3,  1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[1] = '{4'd3,  4'd0, 1'b1, 1'b0, 4'd3,  1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[2] = '{4'd3,  4'd0, 1'b0, 1'b0, 4'd3,  1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{4'd5,  4'd0, 1'b1, 1'b0, 4'd3,  1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{4'd5,  4'd0, 1'b1, 1'b0, 4'd3,  1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{4'd0,  4'd7, 1'b0, 1'b1, 4'd7,  1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{4'd0,  4'd7, 1'b0, 1'b0, 4'd7,  1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{4'd0,  4'd0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[8] = '{4'd0,  4'd0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[9] = '{4'd15, 4'd2, 1'b1, 1'b1, 4'd15, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

      clear_inputs();
      #1 rst = 1'b1;

      // Reset forces all outputs low even with active requests, branch and hazard.
      id_src1      = 4'd3;
      id_uses_src1 = 1'b1;
      exe_dest     = 4'd3;
      exe_wb_en    = 1'b1;
      branch_taken = 1'b1;
      mem_r_en     = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(obs, oc);
         chk6("reset outputs", obs, 6'b0);
         chk16("reset stall_cnt", oc, 16'h0);
      end
      rst = 1'b0;
      clear_inputs();

      // Hazard / branch vectors with the memory FSM idle.
      exp_inc = 0;
      foreach (tbl[i]) begin
         id_src1      = tbl[i].src1;
         id_src2      = tbl[i].src2;
         id_uses_src1 = tbl[i].u1;
         id_two_src   = tbl[i].two;
         exe_dest     = tbl[i].ed;
         exe_wb_en    = tbl[i].ew;
         mem_dest     = tbl[i].md;
         mem_wb_en    = tbl[i].mw;
         branch_taken = tbl[i].br;
         step(obs, oc);
         chk1($sformatf("tbl[%0d] freeze_front", i), obs[5], tbl[i].ff);
         chk1($sformatf("tbl[%0d] flush_if_id", i), obs[3], tbl[i].fi);
         chk1($sformatf("tbl[%0d] flush_id_ex", i), obs[2], tbl[i].fe);
         chk1($sformatf("tbl[%0d] freeze_pipe", i), obs[4], 1'b0);
         if (tbl[i].ff) exp_inc++;
      end
      clear_inputs();
      step(obs, oc);
      chk16("tbl stall_cnt", oc, 16'(exp_inc));

      // Single load: frozen cycles 0-3, done at 4, busy 1-4 (bit i = cycle i).
      exp_fp   = 6'b001111;
      exp_done = 6'b010000;
      exp_busy = 6'b011110;
      for (int i = 0; i < 6; i++) begin
         mem_r_en = (i == 0);
         step(obs, oc);
         chk1($sformatf("load c%0d freeze_pipe", i), obs[4], exp_fp[i]);
         chk1($sformatf("load c%0d freeze_front", i), obs[5], exp_fp[i]);
         chk1($sformatf("load c%0d mem_done", i), obs[0], exp_done[i]);
         chk1($sformatf("load c%0d mem_busy", i), obs[1], exp_busy[i]);
      end

      // Back-to-back stores: 4 frozen / 1 unfrozen, repeating.
      mem_w_en = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step(obs, oc);
         chk1($sformatf("store c%0d freeze_pipe", i), obs[4], (i % 5) < 4);
         chk1($sformatf("store c%0d mem_done", i), obs[0], (i % 5) == 4);
      end
      mem_w_en = 1'b0;

      // Reset at cycle 2 of an access aborts it; FSM stays idle afterwards.
      mem_r_en = 1'b1;
      step(obs, oc);
      mem_r_en = 1'b0;
      step(obs, oc);
      chk1("abort c1 busy", obs[1], 1'b1);
      rst = 1'b1;
      step(obs, oc);
      chk6("abort reset outputs", obs, 6'b0);
      chk16("abort reset stall_cnt", oc, 16'h0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(obs, oc);
         chk6($sformatf("post-abort c%0d outputs", i), obs, 6'b0);
      end

      // Randomized traffic, checked by the model inside step().
      for (int i = 0; i < 400; i++) begin
         rst          = ($urandom_range(0, 49) == 0);
         id_src1      = 4'($urandom_range(0, 3));
         id_src2      = 4'($urandom_range(0, 3));
         id_uses_src1 = 1'($urandom_range(0, 1));
         id_two_src   = 1'($urandom_range(0, 1));
         exe_dest     = 4'($urandom_range(0, 3));
         exe_wb_en    = 1'($urandom_range(0, 1));
         mem_dest     = 4'($urandom_range(0, 3));
         mem_wb_en    = 1'($urandom_range(0, 1));
         branch_taken = ($urandom_range(0, 4) == 0);
         mem_r_en     = ($urandom_range(0, 5) == 0);
         mem_w_en     = ($urandom_range(0, 5) == 0);
         step(obs, oc);
      end
      rst = 1'b0;
      clear_inputs();

      // Saturation: hold a hazard for more than 65535 cycles.
      id_src1      = 4'd3;
      id_uses_src1 = 1'b1;
      exe_dest     = 4'd3;
      exe_wb_en    = 1'b1;
      for (int i = 0; i < 65540; i++) step(obs, oc);
      clear_inputs();
      step(obs, oc);
      chk16("saturated stall_cnt", oc, 16'hFFFF);
      id_src1      = 4'd3;
      id_uses_src1 = 1'b1;
      exe_dest     = 4'd3;
      exe_wb_en    = 1'b1;
      step(obs, oc);
      chk1("saturated freeze_front", obs[5], 1'b1);
      step(obs, oc);
      chk16("saturated no wrap", oc, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
